// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode codes, phase states and field widths for the LED arbiter
//
// Purpose: common definitions used by led_arbiter and its bench.
//   MODE_*  : per-requester display mode codes carried on the mode bus
//   phase_t : LED phase state of the pattern FSM
//   *_W     : field widths of the mode/count buses and of the tick counters
package led_pkg;

  localparam int MODE_W  = 2;
  localparam int COUNT_W = 4;
  localparam int CNT_W   = 16;

  localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_ON    = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BLINK = 2'd2;
  localparam logic [MODE_W-1:0] MODE_CODE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ON_PH  = 2'd1,
    OFF_PH = 2'd2,
    GAP    = 2'd3
  } phase_t;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler emitting a one-cycle tick every DIV clocks
//
// Purpose: pattern time base. Restarting aligns the first tick DIV cycles
// after the restart, so phase durations are exact multiples of DIV.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   restart in  synchronous restart; counter is zero on the next cycle
//   tick    out high for one cycle when the counter reaches DIV-1
module led_tick_gen #(
  parameter int DIV = 16000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_arbiter.sv
// rtl/led_arbiter.sv - fixed-priority LED sharing with minimum dwell and blink patterns
//
// Purpose: picks one requester to own the user LED and drives its pattern
// (OFF, ON, BLINK, CODE pulse trains). Idle keeps the LED solid on.
// Ports:
//   CLK    in  system clock
//   RST_N  in  asynchronous active-low reset
//   req    in  [N_REQ]   level request per requester, index 0 highest priority
//   mode   in  [2*N_REQ] per-requester mode (OFF/ON/BLINK/CODE)
//   count  in  [4*N_REQ] per-requester CODE pulse count, 0 behaves as 1
//   grant  out [N_REQ]   one-hot owner, zero when idle (registered)
//   busy   out           OR of grant (registered)
//   LED    out           LED drive (registered)
module led_arbiter
  import led_pkg::*;
#(
  parameter int CLK_HZ   = 16000000,
  parameter int TICK_HZ  = 1000,
  parameter int N_REQ    = 4,
  parameter int MIN_HOLD = 500,
  parameter int SLOW_T   = 500,
  parameter int CODE_ON  = 200,
  parameter int CODE_OFF = 200,
  parameter int CODE_GAP = 1000
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [N_REQ-1:0]           req,
  input  logic [MODE_W*N_REQ-1:0]    mode,
  input  logic [COUNT_W*N_REQ-1:0]   count,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       LED
);

  localparam int TICK_SAFE = (TICK_HZ > 0) ? TICK_HZ : 1;
  localparam int DIV       = CLK_HZ / TICK_SAFE;

  localparam logic [CNT_W-1:0] HOLD_L = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] SLOW_L = CNT_W'(SLOW_T);
  localparam logic [CNT_W-1:0] ON_L   = CNT_W'(CODE_ON);
  localparam logic [CNT_W-1:0] OFF_L  = CNT_W'(CODE_OFF);
  localparam logic [CNT_W-1:0] GAP_L  = CNT_W'(CODE_GAP);

  if ((TICK_HZ <= 0) || (CLK_HZ < TICK_SAFE) || ((CLK_HZ % TICK_SAFE) != 0) ||
      (N_REQ < 1) || (MIN_HOLD <= 0) || (SLOW_T <= 0) || (CODE_ON <= 0) ||
      (CODE_OFF <= 0) || (CODE_GAP <= 0) || (MIN_HOLD > 65535) || (SLOW_T > 65535) ||
      (CODE_ON > 65535) || (CODE_OFF > 65535) || (CODE_GAP > 65535)) begin : g_param_error
    $error("led_arbiter: CLK_HZ/TICK_HZ must be an exact integer and time parameters nonzero");
  end

  // Registered state
  phase_t             phase_q;
  logic [CNT_W-1:0]   ph_cnt_q;
  logic [CNT_W-1:0]   hold_q;
  logic [COUNT_W-1:0] pulse_q;
  logic [MODE_W-1:0]  mode_q;
  logic [COUNT_W-1:0] count_q;

  // Next-state
  phase_t             phase_d;
  logic [CNT_W-1:0]   ph_cnt_d;
  logic [CNT_W-1:0]   hold_d;
  logic [COUNT_W-1:0] pulse_d;
  logic [MODE_W-1:0]  mode_d;
  logic [COUNT_W-1:0] count_d;
  logic [N_REQ-1:0]   grant_d;

  logic [N_REQ-1:0]   win_oh;
  logic [MODE_W-1:0]  win_mode;
  logic [COUNT_W-1:0] win_count;
  logic [CNT_W-1:0]   limit;
  logic [COUNT_W-1:0] last_pulse;
  logic               any_req;
  logic               owner_live;
  logic               lower_req;
  logic               hold_done;
  logic               take;
  logic               new_grant;
  logic               tick;

  led_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk    (CLK),
    .rst_n  (RST_N),
    .restart(new_grant),
    .tick   (tick)
  );

  // Lowest asserted index wins; scanning downward leaves the lowest one last.
  always_comb begin
    win_oh    = '0;
    win_mode  = MODE_OFF;
    win_count = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_oh    = N_REQ'(1) << i;
        win_mode  = MODE_W'(mode >> (MODE_W * i));
        win_count = COUNT_W'(count >> (COUNT_W * i));
      end
    end
  end

  assign any_req    = |req;
  assign owner_live = |(grant & req);
  // grant-1 of a one-hot owner masks exactly the higher-priority indices.
  assign lower_req  = |(req & (grant - N_REQ'(1)));
  assign hold_done  = (hold_q >= HOLD_L);
  assign take       = any_req && ((grant == '0) || !owner_live || (lower_req && hold_done));
  assign last_pulse = (count_q == '0) ? '0 : (count_q - COUNT_W'(1));

  always_comb begin
    grant_d   = grant;
    phase_d   = phase_q;
    ph_cnt_d  = ph_cnt_q;
    hold_d    = hold_q;
    pulse_d   = pulse_q;
    mode_d    = mode_q;
    count_d   = count_q;
    new_grant = 1'b0;
    limit     = '0;

    // A zero limit means the phase never ends (steady ON or OFF modes).
    case (phase_q)
      ON_PH:   limit = (mode_q == MODE_BLINK) ? SLOW_L : ((mode_q == MODE_CODE) ? ON_L : '0);
      OFF_PH:  limit = (mode_q == MODE_BLINK) ? SLOW_L : ((mode_q == MODE_CODE) ? OFF_L : '0);
      GAP:     limit = GAP_L;
      default: limit = '0;
    endcase

    if ((grant != '0) && !owner_live && !any_req) begin
      grant_d  = '0;
      phase_d  = IDLE;
      ph_cnt_d = '0;
      hold_d   = '0;
      pulse_d  = '0;
    end else if (take) begin
      new_grant = 1'b1;
      grant_d   = win_oh;
      mode_d    = win_mode;
      count_d   = win_count;
      ph_cnt_d  = '0;
      hold_d    = '0;
      pulse_d   = '0;
      phase_d   = (win_mode == MODE_OFF) ? OFF_PH : ON_PH;
    end else if ((phase_q != IDLE) && tick) begin
      if (hold_q != '1) hold_d = hold_q + CNT_W'(1);
      if ((limit != '0) && (ph_cnt_q == (limit - CNT_W'(1)))) begin
        ph_cnt_d = '0;
        case (phase_q)
          ON_PH: phase_d = OFF_PH;
          OFF_PH: begin
            if ((mode_q == MODE_CODE) && (pulse_q == last_pulse)) begin
              phase_d = GAP;
              pulse_d = '0;
            end else begin
              phase_d = ON_PH;
              if (mode_q == MODE_CODE) pulse_d = pulse_q + COUNT_W'(1);
            end
          end
          GAP: begin
            phase_d = ON_PH;
            pulse_d = '0;
          end
          default: phase_d = IDLE;
        endcase
      end else if (ph_cnt_q != '1) begin
        ph_cnt_d = ph_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase_q  <= IDLE;
      ph_cnt_q <= '0;
      hold_q   <= '0;
      pulse_q  <= '0;
      mode_q   <= MODE_OFF;
      count_q  <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      LED      <= 1'b1;
    end else begin
      phase_q  <= phase_d;
      ph_cnt_q <= ph_cnt_d;
      hold_q   <= hold_d;
      pulse_q  <= pulse_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      grant    <= grant_d;
      busy     <= |grant_d;
      LED      <= (phase_d == IDLE) || (phase_d == ON_PH);
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// tb/tb_led_arbiter.sv - scoreboard bench for led_arbiter with DIV=8 timing
module tb_led_arbiter;
  import led_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  mode = '0;
  logic [15:0] count = '0;
  logic [3:0]  grant;
  logic        busy;
  logic        LED;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic       busy;
    logic       led;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  led_arbiter #(
    .CLK_HZ(8), .TICK_HZ(1), .N_REQ(4), .MIN_HOLD(4), .SLOW_T(2),
    .CODE_ON(1), .CODE_OFF(1), .CODE_GAP(3)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .mode(mode), .count(count),
    .grant(grant), .busy(busy), .LED(LED)
  );

  always #5 CLK = ~CLK;

  task automatic push(input int cyc, input logic [3:0] g, input logic l);
    exp_t x;
    x.cyc = cyc; x.grant = g; x.busy = |g; x.led = l;
    sb.push_back(x);
  endtask

  // Leaves the bench at the start of cycle 0, just after a clock edge.
  task automatic do_reset();
    req = '0; mode = '0; count = '0;
    @(negedge CLK); RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    #2 RST_N = 1'b0;
    push(0, 4'b0000, 1'b1);
    #1;
    e = sb.pop_front(); checks++;
    if ({grant, busy, LED} !== {e.grant, e.busy, e.led}) begin
      failures++;
      $display("FAIL reset_async cyc=%0d got grant=%b busy=%b led=%b want grant=%b busy=%b led=%b", e.cyc, grant, busy, LED, e.grant, e.busy, e.led);
    end
    @(negedge CLK); RST_N = 1'b1;
    for (int k = 1; k <= 6; k++) push(k, 4'b0000, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge CLK); @(negedge CLK);
      e = sb.pop_front(); checks++;
      if ({grant, busy, LED} !== {e.grant, e.busy, e.led}) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got grant=%b busy=%b led=%b want grant=%b busy=%b led=%b", e.cyc, grant, busy, LED, e.grant, e.busy, e.led);
      end
    end
  endtask

  // BLINK on req[2]; a lower-priority req[3] from cycle 5 must never preempt.
  task automatic test_blink();
    do_reset();
    for (int k = 1; k <= 40; k++) push(k, 4'b0100, (((k - 1) / 16) % 2) == 0);
    mode[5:4] = MODE_BLINK; req[2] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (k == 5) begin mode[7:6] = MODE_ON; req[3] = 1'b1; end
      @(negedge CLK);
      e = sb.pop_front(); checks++;
      if ({grant, busy, LED} !== {e.grant, e.busy, e.led}) begin
        failures++;
        $display("FAIL blink cyc=%0d got grant=%b busy=%b led=%b want grant=%b busy=%b led=%b", e.cyc, grant, busy, LED, e.grant, e.busy, e.led);
      end
    end
  endtask

  // CODE count=3 on req[1]; mode/count changes at cycle 20 must be ignored.
  task automatic test_code();
    logic l;
    int   pos;
    do_reset();
    for (int k = 1; k <= 90; k++) begin
      pos = (k - 1) % 72;
      l = (pos < 48) ? (((pos / 8) % 2) == 0) : 1'b0;
      push(k, 4'b0010, l);
    end
    mode[3:2] = MODE_CODE; count[7:4] = 4'd3; req[1] = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      @(posedge CLK); #1;
      if (k == 20) begin mode[3:2] = MODE_ON; count[7:4] = 4'd1; end
      @(negedge CLK);
      e = sb.pop_front(); checks++;
      if ({grant, busy, LED} !== {e.grant, e.busy, e.led}) begin
        failures++;
        $display("FAIL code3 cyc=%0d got grant=%b busy=%b led=%b want grant=%b busy=%b led=%b", e.cyc, grant, busy, LED, e.grant, e.busy, e.led);
      end
    end
  endtask

  // CODE with count=0 behaves as a single pulse: 8 on, 8 off, 24 gap.
  task automatic test_code_zero();
    logic l;
    int   pos;
    do_reset();
    for (int k = 1; k <= 50; k++) begin
      pos = (k - 1) % 40;
      l = (pos < 8);
      push(k, 4'b0001, l);
    end
    mode[1:0] = MODE_CODE; count[3:0] = 4'd0; req[0] = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge CLK); @(negedge CLK);
      e = sb.pop_front(); checks++;
      if ({grant, busy, LED} !== {e.grant, e.busy, e.led}) begin
        failures++;
        $display("FAIL code0 cyc=%0d got grant=%b busy=%b led=%b want grant=%b busy=%b led=%b", e.cyc, grant, busy, LED, e.grant, e.busy, e.led);
      end
    end
  endtask

  task automatic test_preempt();
    do_reset();
    for (int k = 1; k <= 40; k++) push(k, (k <= 33) ? 4'b1000 : 4'b0001, (k <= 33));
    mode[7:6] = MODE_ON; mode[1:0] = MODE_OFF; req[3] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (k == 10) req[0] = 1'b1;
      @(negedge CLK);
      e = sb.pop_front(); checks++;
      if ({grant, busy, LED} !== {e.grant, e.busy, e.led}) begin
        failures++;
        $display("FAIL preempt cyc=%0d got grant=%b busy=%b led=%b want grant=%b busy=%b led=%b", e.cyc, grant, busy, LED, e.grant, e.busy, e.led);
      end
    end
  endtask

  // Owner drops at 20 with nobody else, then re-requests at 25: pattern restarts.
  task automatic test_drop_idle();
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      if (k <= 20)      push(k, 4'b0100, k <= 16);
      else if (k <= 25) push(k, 4'b0000, 1'b1);
      else              push(k, 4'b0100, k <= 41);
    end
    mode[5:4] = MODE_BLINK; req[2] = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge CLK); #1;
      if (k == 20) req[2] = 1'b0;
      if (k == 25) req[2] = 1'b1;
      @(negedge CLK);
      e = sb.pop_front(); checks++;
      if ({grant, busy, LED} !== {e.grant, e.busy, e.led}) begin
        failures++;
        $display("FAIL drop_idle cyc=%0d got grant=%b busy=%b led=%b want grant=%b busy=%b led=%b", e.cyc, grant, busy, LED, e.grant, e.busy, e.led);
      end
    end
  endtask

  // Owner req[1] drops at 20 while req[2] rises: handover with no idle cycle.
  task automatic test_drop_switch();
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      if (k <= 20) push(k, 4'b0010, 1'b0);
      else         push(k, 4'b0100, k <= 36);
    end
    mode[3:2] = MODE_OFF; mode[5:4] = MODE_BLINK; req[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (k == 20) begin req[1] = 1'b0; req[2] = 1'b1; end
      @(negedge CLK);
      e = sb.pop_front(); checks++;
      if ({grant, busy, LED} !== {e.grant, e.busy, e.led}) begin
        failures++;
        $display("FAIL drop_switch cyc=%0d got grant=%b busy=%b led=%b want grant=%b busy=%b led=%b", e.cyc, grant, busy, LED, e.grant, e.busy, e.led);
      end
    end
  endtask

  task automatic test_async_reset();
    logic l;
    do_reset();
    for (int k = 1; k <= 12; k++) push(k, 4'b0010, (((k - 1) / 8) % 2) == 0);
    mode[3:2] = MODE_CODE; count[7:4] = 4'd2; req[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge CLK); @(negedge CLK);
      e = sb.pop_front(); checks++;
      if ({grant, busy, LED} !== {e.grant, e.busy, e.led}) begin
        failures++;
        $display("FAIL arst_pre cyc=%0d got grant=%b busy=%b led=%b want grant=%b busy=%b led=%b", e.cyc, grant, busy, LED, e.grant, e.busy, e.led);
      end
    end
    #2 RST_N = 1'b0;
    push(0, 4'b0000, 1'b1);
    #1;
    e = sb.pop_front(); checks++;
    if ({grant, busy, LED} !== {e.grant, e.busy, e.led}) begin
      failures++;
      $display("FAIL arst_now got grant=%b busy=%b led=%b want grant=%b busy=%b led=%b", grant, busy, LED, e.grant, e.busy, e.led);
    end
    req = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    for (int k = 1; k <= 40; k++) begin
      l = ((k - 1) < 32) ? ((((k - 1) / 8) % 2) == 0) : 1'b0;
      push(k, 4'b0010, l);
    end
    req[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); @(negedge CLK);
      e = sb.pop_front(); checks++;
      if ({grant, busy, LED} !== {e.grant, e.busy, e.led}) begin
        failures++;
        $display("FAIL arst_post cyc=%0d got grant=%b busy=%b led=%b want grant=%b busy=%b led=%b", e.cyc, grant, busy, LED, e.grant, e.busy, e.led);
      end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_code();
    test_code_zero();
    test_preempt();
    test_drop_idle();
    test_drop_switch();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_arbiter.md
Name: led_arbiter

Overview:
- Shares the single on-board user LED of the TinyFPGA BX among several on-chip requesters (boot status, CPU run/halt, fault codes).
- Each requester supplies a display mode; the block arbitrates by fixed priority with a minimum dwell time and generates the blink timing.
- Sits between internal status logic and the top-level LED pin; idle state keeps the LED solid on (user-program-mode indication).

Parameters:
- CLK_HZ, 16000000, input clock frequency
- TICK_HZ, 1000, pattern time base; DIV = CLK_HZ/TICK_HZ cycles per tick, must divide exactly
- N_REQ, 4, number of requesters; index 0 is highest priority
- MIN_HOLD, 500, ticks a grant is held before higher-priority preemption
- SLOW_T, 500, BLINK half-period in ticks
- CODE_ON, 200, CODE pulse on-time in ticks
- CODE_OFF, 200, CODE inter-pulse off-time in ticks
- CODE_GAP, 1000, CODE off-time after the last pulse in ticks

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- req  in  N_REQ  request per requester, level
- mode  in  2*N_REQ  per-requester mode: 0 OFF, 1 ON, 2 BLINK, 3 CODE
- count  in  4*N_REQ  per-requester CODE pulse count; 0 treated as 1
- grant  out  N_REQ  one-hot owner, all-zero when idle
- busy  out  1  OR of grant
- LED  out  1  LED drive, registered

Behaviour:
- Reset: async on RST_N low. grant=0, busy=0, LED=1, FSM=IDLE, prescaler, phase and hold counters = 0. Takes effect immediately, with no clock edge needed.
- Latency: all outputs are registered. A decision on cycle n is visible on cycle n+1.
- Arbitration: grant goes to the lowest-index asserted req when any of these is true:
  - the block is idle;
  - the owner deasserts req;
  - a lower-index req is asserted and hold_done=1.
- Otherwise the grant is unchanged. An equal- or lower-priority req never preempts.
- On each new grant:
  - latch mode/count of the winner; later changes are ignored until the next grant;
  - restart the prescaler, phase timer and hold counter;
  - enter the initial phase.
- hold_done: a saturating tick count since grant reaches MIN_HOLD. For a grant visible at cycle g, hold_done is true from cycle g+MIN_HOLD*DIV. A preempting grant is visible one cycle later.
- Phase states: IDLE, ON_PH, OFF_PH, GAP.
  - IDLE: LED=1.
  - OFF: OFF_PH forever.
  - ON: ON_PH forever.
  - BLINK: ON_PH SLOW_T ticks, then OFF_PH SLOW_T ticks, repeating.
  - CODE: ON_PH CODE_ON, then OFF_PH CODE_OFF, repeated count times (pulse counter). After the last OFF_PH, GAP for CODE_GAP ticks, then ON_PH with the pulse counter reset.
  - LED=1 in ON_PH, LED=0 in OFF_PH and GAP.
- Phase timing is exact: a T-tick phase lasts T*DIV cycles, because the prescaler restarts at grant.
- Simultaneous owner drop and other req: the new winner is granted next cycle, with no idle cycle.
- Owner drops with no other req: IDLE, grant=0, LED=1 next cycle.
- A re-grant to the same index after a drop restarts the pattern.
- Widths:
  - prescaler: clog2(DIV) bits;
  - phase/hold counters: 16 bits, saturating;
  - pulse counter: 4 bits.
- Elaboration error if DIV is not an integer or any time parameter is 0.

Decomposition:
- Package led_pkg holds the mode codes (OFF/ON/BLINK/CODE), the phase-state enum and the mode/count field widths.
- One sub-module, led_tick_gen: prescaler with synchronous restart input, emitting a one-cycle tick every DIV cycles.
- The arbiter and phase FSM stay in led_arbiter.

Test Plan (overrides CLK_HZ=8, TICK_HZ=1 so DIV=8, MIN_HOLD=4, SLOW_T=2, CODE_ON=1, CODE_OFF=1, CODE_GAP=3, N_REQ=4):
- Reset: RST_N low then high, no req -> LED=1, grant=4'b0000, busy=0 throughout.
- Blink: req[2]=1, mode[2]=BLINK at cycle 0 -> grant=4'b0100 at cycle 1; LED=1 cycles 1-16, 0 cycles 17-32, 1 from cycle 33.
- Code: req[1], mode=CODE, count=3 at cycle 0 -> LED runs 1,0,1,0,1,0 in 8-cycle segments from cycle 1, then 0 for 24 cycles, then repeats from cycle 73.
- Preempt after hold: req[3] granted at cycle 1, req[0] asserted at cycle 10 -> grant=4'b1000 through cycle 33, grant=4'b0001 at cycle 34.
- Drop cases: owner drops req at cycle 20, others idle -> grant=0, LED=1 at cycle 21. Same drop with req[2] asserted at cycle 20 -> grant=4'b0100 at cycle 21.
- Async reset: RST_N low mid-CODE between clock edges -> LED=1, grant=0 immediately; pattern restarts from ON_PH after release and re-request.
